// File: rtl/addsub_bist.sv
// addsub_bist: exhaustive built-in self-test controller for a W-bit adder/subtractor.
// Define ADDSUB_BIST_STOP_ON_FAIL_EN to halt the sweep at the first mismatching vector.
module addsub_bist #(
   parameter int unsigned W       = 4,
   parameter int unsigned DUT_LAT = 0,
   parameter int unsigned ERR_W   = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [W-1:0]     dut_a,
   output logic [W-1:0]     dut_b,
   output logic             dut_sel,
   input  logic [W-1:0]     dut_sum,
   input  logic             dut_cout,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [2*W:0]     fail_vec
);

   localparam int unsigned VW      = 2 * W + 1;
   localparam int unsigned LatW    = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
   localparam int unsigned LatLoad = (DUT_LAT > 0) ? DUT_LAT - 1 : 0;

   typedef enum logic [2:0] {
      StIdle,
      StApply,
      StSettle,
      StCheck,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [VW-1:0]    vc_q, vc_d;
   logic [LatW-1:0]  lat_q, lat_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             sel_q, sel_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [VW-1:0]    fv_q, fv_d;

   logic [W:0]       golden;
   logic [W:0]       observed;
   logic             mismatch;
   logic             last_vec;
   logic             err_sat;

   // Golden model works from the registered operands the DUT actually sees.
   always_comb begin
      golden   = {1'b0, a_q} + {1'b0, (sel_q ? ~b_q : b_q)} + {{W{1'b0}}, sel_q};
      observed = {dut_cout, dut_sum};
      mismatch = (golden != observed);
      last_vec = &vc_q;
      err_sat  = &err_q;
   end

   always_comb begin
      state_d = state_q;
      vc_d    = vc_q;
      lat_d   = lat_q;
      a_d     = a_q;
      b_d     = b_q;
      sel_d   = sel_q;
      err_d   = err_q;
      fv_d    = fv_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               err_d   = '0;
               fv_d    = '0;
               vc_d    = '0;
               state_d = StApply;
            end
         end

         StApply: begin
            b_d   = vc_q[W-1:0];
            a_d   = vc_q[2*W-1:W];
            sel_d = vc_q[2*W];
            if (DUT_LAT > 0) begin
               lat_d   = LatW'(LatLoad);
               state_d = StSettle;
            end else begin
               state_d = StCheck;
            end
         end

         StSettle: begin
            if (lat_q == '0) begin
               state_d = StCheck;
            end else begin
               lat_d = lat_q - LatW'(1);
            end
         end

         StCheck: begin
            if (mismatch) begin
               if (!err_sat) begin
                  err_d = err_q + ERR_W'(1);
               end
               if (err_q == '0) begin
                  fv_d = vc_q;
               end
            end
`ifdef ADDSUB_BIST_STOP_ON_FAIL_EN
            if (mismatch || last_vec) begin
               state_d = StDone;
            end else begin
               vc_d    = vc_q + VW'(1);
               state_d = StApply;
            end
`else
            if (last_vec) begin
               state_d = StDone;
            end else begin
               vc_d    = vc_q + VW'(1);
               state_d = StApply;
            end
`endif
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         vc_q    <= '0;
         lat_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= 1'b0;
         err_q   <= '0;
         fv_q    <= '0;
      end else begin
         state_q <= state_d;
         vc_q    <= vc_d;
         lat_q   <= lat_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
      end
   end

   // Status is decoded straight from the state register so it tracks reset asynchronously.
   always_comb begin
      busy = (state_q == StApply) || (state_q == StSettle) || (state_q == StCheck);
      done = (state_q == StDone);
      pass = (state_q == StDone) && (err_q == '0);
   end

   assign dut_a     = a_q;
   assign dut_b     = b_q;
   assign dut_sel   = sel_q;
   assign err_count = err_q;
   assign fail_vec  = fv_q;

endmodule

// File: tb/tb_addsub_bist.sv
// Testbench for addsub_bist: model AddSub variants (correct, faulty, pipelined) feed four
// controller instances; expectations come from an arithmetic reference of the AddSub contract.
module tb_addsub_bist;

`ifdef ADDSUB_BIST_STOP_ON_FAIL_EN
   localparam bit Stop = 1'b1;
`else
   localparam bit Stop = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   always #5 clk = ~clk;

   int total = 0;
   int bad_cnt = 0;

   // u0: W=4, DUT_LAT=0, fault-selectable combinational model
   logic [3:0] u0_a, u0_b, u0_sum;
   logic       u0_sel, u0_cout, u0_busy, u0_done, u0_pass;
   logic [9:0] u0_err;
   logic [8:0] u0_fv;
   // u1: DUT_LAT=2 with 2-stage pipelined correct model
   logic [3:0] u1_a, u1_b, u1_sum;
   logic       u1_sel, u1_cout, u1_busy, u1_done, u1_pass;
   logic [9:0] u1_err;
   logic [8:0] u1_fv;
   // u2: DUT_LAT=0 with the same pipelined model (latency mismatch)
   logic [3:0] u2_a, u2_b, u2_sum;
   logic       u2_sel, u2_cout, u2_busy, u2_done, u2_pass;
   logic [9:0] u2_err;
   logic [8:0] u2_fv;
   // u3: ERR_W=4, sum forced to zero
   logic [3:0] u3_a, u3_b, u3_sum;
   logic       u3_sel, u3_cout, u3_busy, u3_done, u3_pass;
   logic [3:0] u3_err;
   logic [8:0] u3_fv;

   int         mode;
   bit         bad [512];
   logic [4:0] u0_r, u3_r;
   logic [4:0] p1_s1, p1_s2, p2_s1, p2_s2;

   function automatic logic [4:0] ref_res(input logic sel, input logic [3:0] a,
                                          input logic [3:0] b);
      int ia, ib, r;
      ia = int'(a);
      ib = int'(b);
      if (!sel) r = ia + ib;
      else if (ia >= ib) r = 16 + (ia - ib);   // no borrow: cout=1
      else r = ia - ib + 16;                   // borrow: cout=0, sum wraps
      return 5'(r);
   endfunction

   always_comb begin
      u0_r = ref_res(u0_sel, u0_a, u0_b);
      case (mode)
         1: u0_r[4] = 1'b0;
         2: u0_r[0] = 1'b0;
         3: u0_r[3:0] = 4'd0;
         4: if (bad[{u0_sel, u0_a, u0_b}]) u0_r[1] = ~u0_r[1];
         default: ;
      endcase
   end
   assign {u0_cout, u0_sum} = u0_r;

   always @(posedge clk) begin
      p1_s1 <= ref_res(u1_sel, u1_a, u1_b);
      p1_s2 <= p1_s1;
      p2_s1 <= ref_res(u2_sel, u2_a, u2_b);
      p2_s2 <= p2_s1;
   end
   assign {u1_cout, u1_sum} = p1_s2;
   assign {u2_cout, u2_sum} = p2_s2;

   assign u3_r    = ref_res(u3_sel, u3_a, u3_b);
   assign u3_cout = u3_r[4];
   assign u3_sum  = 4'd0;

   addsub_bist #(.W(4), .DUT_LAT(0), .ERR_W(10)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .dut_a(u0_a), .dut_b(u0_b), .dut_sel(u0_sel),
      .dut_sum(u0_sum), .dut_cout(u0_cout), .busy(u0_busy), .done(u0_done), .pass(u0_pass),
      .err_count(u0_err), .fail_vec(u0_fv));
   addsub_bist #(.W(4), .DUT_LAT(2), .ERR_W(10)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .dut_a(u1_a), .dut_b(u1_b), .dut_sel(u1_sel),
      .dut_sum(u1_sum), .dut_cout(u1_cout), .busy(u1_busy), .done(u1_done), .pass(u1_pass),
      .err_count(u1_err), .fail_vec(u1_fv));
   addsub_bist #(.W(4), .DUT_LAT(0), .ERR_W(10)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .dut_a(u2_a), .dut_b(u2_b), .dut_sel(u2_sel),
      .dut_sum(u2_sum), .dut_cout(u2_cout), .busy(u2_busy), .done(u2_done), .pass(u2_pass),
      .err_count(u2_err), .fail_vec(u2_fv));
   addsub_bist #(.W(4), .DUT_LAT(0), .ERR_W(4)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start), .dut_a(u3_a), .dut_b(u3_b), .dut_sel(u3_sel),
      .dut_sum(u3_sum), .dut_cout(u3_cout), .busy(u3_busy), .done(u3_done), .pass(u3_pass),
      .err_count(u3_err), .fail_vec(u3_fv));

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad_cnt++;
         $display("FAIL %s: got=%0d want=%0d", name, act, exp);
      end
   endtask

   // Pulse start, optionally poke start again mid-run, and wait for every instance to finish.
   task automatic sweep(input int poke_at, output int c0, output int c1, output bit ok);
      c0 = 0;
      c1 = 0;
      ok = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_rise", int'(u0_busy), 1);
      for (int i = 0; i < 5000; i++) begin
         if (u0_done && u1_done && u2_done && u3_done) begin
            ok = 1'b1;
            break;
         end
         if (u0_busy) c0++;
         if (u1_busy) c1++;
         @(negedge clk);
         start = (i == poke_at);
      end
      start = 1'b0;
      chk("sweep_finished", int'(ok), 1);
   endtask

   task automatic check_u0(input string tag, input int exp_err_full, input int exp_fv,
                           input int c0);
      int exp_err, exp_cyc, exp_hold;
      bit stopped;
      stopped  = Stop && (exp_err_full > 0);
      exp_err  = stopped ? 1 : exp_err_full;
      exp_cyc  = stopped ? (exp_fv + 1) * 2 : 1024;
      exp_hold = stopped ? exp_fv : 511;
      chk({tag, "_done"}, int'(u0_done), 1);
      chk({tag, "_pass"}, int'(u0_pass), (exp_err_full == 0) ? 1 : 0);
      chk({tag, "_err"}, int'(u0_err), exp_err);
      chk({tag, "_fail_vec"}, int'(u0_fv), exp_fv);
      chk({tag, "_busy_cycles"}, c0, exp_cyc);
      chk({tag, "_dut_hold"}, int'({u0_sel, u0_a, u0_b}), exp_hold);
   endtask

   typedef struct {
      int    mode;
      int    err_full;
      int    fv;
      string name;
   } row_t;

   row_t rows[4];

   initial begin
      int  c0, c1, k, cnt, first;
      bit  ok;
      rows[0] = '{0, 0, 0, "correct"};
      rows[1] = '{1, 256, 9'h01F, "cout_stuck0"};
      rows[2] = '{2, 256, 9'h001, "sum0_stuck0"};
      rows[3] = '{3, 480, 9'h001, "sum_zero"};

      rst_n = 1'b0;
      start = 1'b0;
      mode  = 0;
      for (int i = 0; i < 512; i++) bad[i] = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_dut", int'({u0_sel, u0_a, u0_b}), 0);
      chk("rst_busy", int'(u0_busy), 0);
      chk("rst_done", int'(u0_done), 0);
      chk("rst_pass", int'(u0_pass), 0);
      chk("rst_err", int'(u0_err), 0);
      chk("rst_fv", int'(u0_fv), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy_before_start", int'(u0_busy), 0);

      for (int r = 0; r < 4; r++) begin
         mode = rows[r].mode;
         sweep((r == 0) ? 300 : -1, c0, c1, ok);
         check_u0(rows[r].name, rows[r].err_full, rows[r].fv, c0);
         if (r == 0) begin
            chk("lat2_pass", int'(u1_pass), 1);
            chk("lat2_err", int'(u1_err), 0);
            chk("lat2_busy_cycles", c1, 2048);
            chk("lat_mismatch_pass", int'(u2_pass), 0);
            chk("errw4_err", int'(u3_err), Stop ? 1 : 15);
            chk("errw4_pass", int'(u3_pass), 0);
         end
      end

      // Random single-bit faults at a random set of vectors.
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < 512; i++) bad[i] = 1'b0;
         k = $urandom_range(1, 12);
         for (int j = 0; j < k; j++) bad[$urandom_range(0, 511)] = 1'b1;
         cnt = 0;
         first = 0;
         for (int i = 511; i >= 0; i--) begin
            if (bad[i]) begin
               cnt++;
               first = i;
            end
         end
         mode = 4;
         sweep(-1, c0, c1, ok);
         check_u0("rand", cnt, first, c0);
      end

      // start held high: new run begins on the first DONE cycle.
      mode = 0;
      @(negedge clk);
      start = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (u0_done) begin
            ok = 1'b1;
            break;
         end
      end
      chk("held_start_done_seen", int'(ok), 1);
      @(negedge clk);
      chk("held_start_done_one_cycle", int'(u0_done), 0);
      chk("held_start_restart_busy", int'(u0_busy), 1);
      start = 1'b0;

      // Asynchronous reset in the middle of a faulty run, then a clean restart.
      mode = 1;
      repeat (200) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_dut", int'({u0_sel, u0_a, u0_b}), 0);
      chk("midrst_busy", int'(u0_busy), 0);
      chk("midrst_done", int'(u0_done), 0);
      chk("midrst_err", int'(u0_err), 0);
      chk("midrst_fv", int'(u0_fv), 0);
      @(negedge clk);
      rst_n = 1'b1;
      mode = 0;
      sweep(-1, c0, c1, ok);
      check_u0("after_reset", 0, 0, c0);

      $display("test done: total=%0d bad=%0d", total, bad_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
